ex_stage: RTL
=============

Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS-32 pipeline.
- Consumes the registered ID/EX bundle: operands, immediate, register addresses, control bits and PC.
- Computes the ALU result, zero flag, branch target and destination register, then registers them into the EX/MEM bundle.
- MUL is iterative and multi-cycle; this stage stalls upstream while it runs and inserts bubbles downstream.

Parameters:
- MUL_CYCLES, 32, number of shift-add iterations; must equal the data width.
- WIDTH, 32, datapath width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  ID/EX bundle holds a real instruction.
- a, b  in  32  register operands.
- imm  in  32  sign-extended immediate.
- pc  in  32  PC+4 of the instruction.
- jump_target  in  32  precomputed jump address; passed through unchanged.
- rd, rt  in  5  destination candidates.
- reg_dst, alu_src, branch, mem_read, mem_to_reg, mem_write, reg_write, jump  in  1 each  control bits.
- alu_op  in  3  operation code.
- flush  in  1  kill the current instruction (taken branch resolved downstream).
- stall_o  out  1  upstream must hold PC, IF/ID and ID/EX contents.
- o_alu_result  out  32  registered ALU result.
- o_zero  out  1  registered (o_alu_result == 0).
- o_branch_target  out  32  registered pc + (imm << 2).
- o_jump_target  out  32  registered pass-through of jump_target.
- o_store_data  out  32  registered b.
- o_wreg  out  5  registered destination register.
- o_branch, o_mem_read, o_mem_to_reg, o_mem_write, o_reg_write, o_jump  out  1 each  registered control bits.

Behaviour:
- Reset: every o_* output is 0, FSM is IDLE, iteration counter is 0, stall_o is 0. A reset arriving mid-MUL abandons the MUL with no result.
- Operand B: b when alu_src = 0, imm when alu_src = 1.
- Destination: wreg = reg_dst ? rd : rt.
- alu_op encoding:
  - 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT (signed, result 0 or 1), 101 NOR, 110 XOR: all wrap mod 2^32.
  - 111 MUL: low 32 bits of the unsigned product.
- Single-cycle ops: results register on the next edge; latency 1 cycle.
- Bubble: all six o_* control bits are 0; data outputs are don't-care.
- Bubble conditions: in_valid = 0, flush = 1, or stall_o = 1. A bubble is registered on each such edge.
- FSM:
  - IDLE: when in_valid & alu_op = MUL & !flush, latch the operands, clear the counter and go to BUSY. stall_o is high combinationally in this cycle.
  - BUSY: one shift-add step per cycle. stall_o = 1. When counter = MUL_CYCLES-1, go to DONE.
  - DONE: stall_o = 0. The product and control bits register to the outputs on this edge; go to IDLE.
- MUL timing: stall_o is high for MUL_CYCLES+1 cycles and the result appears MUL_CYCLES+2 edges after first presentation.
- stall_o = (state == BUSY) | (state == IDLE & in_valid & alu_op == MUL).
- flush in any state: return to IDLE, register a bubble, stall_o low in the following cycle. Flush has priority over MUL start and over completion.
- Upstream holds inputs stable while stall_o is high. This stage does not re-sample operands during BUSY.

Optional Feature:
- Macro EX_OVERFLOW_EN.
- Defined:
  - ADD/SUB signed overflow drives an extra output o_ovf (1 bit, registered, reset 0).
  - On overflow, o_reg_write is forced to 0 (result discarded).
- Undefined:
  - No o_ovf port.
  - Arithmetic wraps and reg_write passes through unchanged.

Decomposition:
- Package ex_pkg holds:
  - alu_op localparams (ALU_ADD … ALU_MUL);
  - FSM state encoding (IDLE, BUSY, DONE);
  - MUL_CYCLES default.
- One sub-module, mul_iter: the shift-add multiplier with start/flush/busy/done and a 32-bit product.
- ALU, muxes and the EX/MEM register stay in ex_stage.

Test Plan:
- Reset, then ADD a=5, b=7, alu_src=0, reg_dst=1, rd=3, reg_write=1 -> next edge: o_alu_result=12, o_zero=0, o_wreg=3, o_reg_write=1.
- SUB a=7, b=7, branch=1, pc=0x100, imm=4 -> o_alu_result=0, o_zero=1, o_branch_target=0x110, o_branch=1.
- MUL a=6, b=7, held stable -> stall_o high 33 cycles, 33 bubbles (o_reg_write=0), then o_alu_result=42 with o_reg_write=1, and stall_o low.
- MUL 0xFFFFFFFF×2 with flush pulsed in BUSY cycle 10 -> bubble, state IDLE, stall_o low next cycle, no product ever appears.
- rst asserted mid-MUL -> all outputs 0 and stall_o 0 on the next edge; a following ADD 1+1 completes normally with result 2.
- ADD 0x7FFFFFFF+1, reg_write=1 -> with EX_OVERFLOW_EN: o_ovf=1, o_reg_write=0; without it: o_alu_result=0x80000000, o_reg_write=1.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared constants for the MIPS-32 execute stage: ALU op codes, multiplier FSM
// encoding and default sizes.
package ex_pkg;

  localparam int WIDTH_DEF      = 32;
  localparam int MUL_CYCLES_DEF = 32;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_NOR = 3'b101;
  localparam logic [2:0] ALU_XOR = 3'b110;
  localparam logic [2:0] ALU_MUL = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Two's-complement overflow of x +/- y given the wrapped result r.
  function automatic logic signed_ovf(input logic sub,
                                      input logic [WIDTH_DEF-1:0] x,
                                      input logic [WIDTH_DEF-1:0] y,
                                      input logic [WIDTH_DEF-1:0] r);
    logic same_sign;
    same_sign  = sub ? (x[WIDTH_DEF-1] != y[WIDTH_DEF-1]) : (x[WIDTH_DEF-1] == y[WIDTH_DEF-1]);
    signed_ovf = same_sign && (r[WIDTH_DEF-1] != x[WIDTH_DEF-1]);
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX input bundle and EX/MEM output bundle of the execute stage.
// With EX_OVERFLOW_EN defined the bundle also carries o_ovf.
interface ex_stage_if #(parameter int WIDTH = 32);

  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] imm;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] jump_target;
  logic [4:0]       rd;
  logic [4:0]       rt;
  logic             reg_dst;
  logic             alu_src;
  logic             branch;
  logic             mem_read;
  logic             mem_to_reg;
  logic             mem_write;
  logic             reg_write;
  logic             jump;
  logic [2:0]       alu_op;
  logic             flush;

  logic             stall_o;
  logic [WIDTH-1:0] o_alu_result;
  logic             o_zero;
  logic [WIDTH-1:0] o_branch_target;
  logic [WIDTH-1:0] o_jump_target;
  logic [WIDTH-1:0] o_store_data;
  logic [4:0]       o_wreg;
  logic             o_branch;
  logic             o_mem_read;
  logic             o_mem_to_reg;
  logic             o_mem_write;
  logic             o_reg_write;
  logic             o_jump;
`ifdef EX_OVERFLOW_EN
  logic             o_ovf;
`endif

  modport master (
    output in_valid, a, b, imm, pc, jump_target, rd, rt,
    output reg_dst, alu_src, branch, mem_read, mem_to_reg, mem_write, reg_write, jump,
    output alu_op, flush,
    input  stall_o, o_alu_result, o_zero, o_branch_target, o_jump_target, o_store_data,
    input  o_wreg, o_branch, o_mem_read, o_mem_to_reg, o_mem_write, o_reg_write, o_jump
`ifdef EX_OVERFLOW_EN
    , input o_ovf
`endif
  );

  modport slave (
    input  in_valid, a, b, imm, pc, jump_target, rd, rt,
    input  reg_dst, alu_src, branch, mem_read, mem_to_reg, mem_write, reg_write, jump,
    input  alu_op, flush,
    output stall_o, o_alu_result, o_zero, o_branch_target, o_jump_target, o_store_data,
    output o_wreg, o_branch, o_mem_read, o_mem_to_reg, o_mem_write, o_reg_write, o_jump
`ifdef EX_OVERFLOW_EN
    , output o_ovf
`endif
  );

endinterface

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, low WIDTH bits
// of the unsigned product are valid while done is high.
module mul_iter
  import ex_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int MUL_CYCLES = MUL_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             idle,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;

  // Multiplicand walks left, multiplier walks right; bits shifted past WIDTH
  // never reach the low half of the product so they are simply dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (flush) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
            cnt    <= '0;
            state  <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(MUL_CYCLES - 1)) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign idle    = (state == ST_IDLE);
  assign busy    = (state == ST_BUSY);
  assign done    = (state == ST_DONE);
  assign product = acc;

endmodule

// File: rtl/ex_stage.sv
// MIPS-32 execute stage: ALU, operand/destination muxes, iterative MUL and the
// EX/MEM register. Define EX_OVERFLOW_EN to add ADD/SUB overflow trapping (o_ovf).
module ex_stage
  import ex_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int MUL_CYCLES = MUL_CYCLES_DEF
) (
  input logic         clk,
  input logic         rst,
  ex_stage_if.slave   bus
);

  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] mul_product;
  logic [4:0]       wreg;
  logic             mul_req;
  logic             mul_idle;
  logic             mul_busy;
  logic             mul_done;
  logic             stall;
  logic             issue;

  assign op_b    = bus.alu_src ? bus.imm : bus.b;
  assign wreg    = bus.reg_dst ? bus.rd : bus.rt;
  assign mul_req = bus.in_valid && (bus.alu_op == ALU_MUL);

  // Stall is raised in the very cycle a MUL shows up so upstream freezes
  // before the multiplier has even latched its operands.
  assign stall       = mul_busy | (mul_idle & mul_req);
  assign bus.stall_o = stall;
  assign issue       = bus.in_valid & ~bus.flush & ~stall;

  mul_iter #(
    .WIDTH      (WIDTH),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_idle & mul_req & ~bus.flush),
    .flush   (bus.flush),
    .a       (bus.a),
    .b       (op_b),
    .idle    (mul_idle),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    alu_res = '0;
    case (bus.alu_op)
      ALU_ADD: alu_res = bus.a + op_b;
      ALU_SUB: alu_res = bus.a - op_b;
      ALU_AND: alu_res = bus.a & op_b;
      ALU_OR:  alu_res = bus.a | op_b;
      ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(op_b))};
      ALU_NOR: alu_res = ~(bus.a | op_b);
      ALU_XOR: alu_res = bus.a ^ op_b;
      ALU_MUL: alu_res = mul_done ? mul_product : '0;
    endcase
  end

`ifdef EX_OVERFLOW_EN
  logic ovf;
  always_comb begin
    ovf = 1'b0;
    if (bus.alu_op == ALU_ADD) ovf = signed_ovf(1'b0, bus.a, op_b, alu_res);
    if (bus.alu_op == ALU_SUB) ovf = signed_ovf(1'b1, bus.a, op_b, alu_res);
  end
`endif

  // Data fields register every cycle; only the control bits are gated, which
  // is all a bubble needs downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.o_alu_result    <= '0;
      bus.o_zero          <= 1'b0;
      bus.o_branch_target <= '0;
      bus.o_jump_target   <= '0;
      bus.o_store_data    <= '0;
      bus.o_wreg          <= '0;
      bus.o_branch        <= 1'b0;
      bus.o_mem_read      <= 1'b0;
      bus.o_mem_to_reg    <= 1'b0;
      bus.o_mem_write     <= 1'b0;
      bus.o_reg_write     <= 1'b0;
      bus.o_jump          <= 1'b0;
`ifdef EX_OVERFLOW_EN
      bus.o_ovf           <= 1'b0;
`endif
    end else begin
      bus.o_alu_result    <= alu_res;
      bus.o_zero          <= (alu_res == '0);
      bus.o_branch_target <= bus.pc + (bus.imm << 2);
      bus.o_jump_target   <= bus.jump_target;
      bus.o_store_data    <= bus.b;
      bus.o_wreg          <= wreg;
      bus.o_branch        <= issue & bus.branch;
      bus.o_mem_read      <= issue & bus.mem_read;
      bus.o_mem_to_reg    <= issue & bus.mem_to_reg;
      bus.o_mem_write     <= issue & bus.mem_write;
      bus.o_jump          <= issue & bus.jump;
`ifdef EX_OVERFLOW_EN
      bus.o_reg_write     <= issue & bus.reg_write & ~ovf;
      bus.o_ovf           <= issue & ovf;
`else
      bus.o_reg_write     <= issue & bus.reg_write;
`endif
    end
  end

endmodule
